// File: rtl/systolic_buffer_ctrl.sv
// Fill/drain sequencer for the systolic output row buffer; `SYSBUF_PROTOCOL_CHECK_EN adds err_sticky.
// Drain presents the first row 1 cycle after DRAIN entry, then 1 row/clk, holding the address under out_ready=0.
module systolic_buffer_ctrl #(
  parameter int N_SIZE     = 32,
  parameter int ROWS       = 512,
  parameter int DEPTH      = 543,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic                  out_ready,
  output logic                  buf_we,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
`ifdef SYSBUF_PROTOCOL_CHECK_EN
  ,
  output logic                  err_sticky
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] SKEW_ROW = ADDR_WIDTH'(N_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   wr_ptr, wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0]   rd_ptr, rd_ptr_nxt;
  logic                    out_valid_nxt;
  logic                    fire;

  assign fire        = out_valid && out_ready;
  assign buf_wr_addr = wr_ptr;
  // Prefetch: on fire the next row is read now so it lands with the next out_valid cycle.
  assign buf_rd_addr = fire ? rd_ptr + 1'b1 : rd_ptr;
  assign out_last    = out_valid && (rd_ptr == LAST_ROW);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= SKEW_ROW;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    out_valid_nxt = out_valid;
    buf_we        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = FILL;
          wr_ptr_nxt = '0;
        end
      end
      FILL: begin
        buf_we = in_valid;
        if (in_valid) begin
          wr_ptr_nxt = wr_ptr + 1'b1;
          if (wr_ptr == LAST_ROW) begin
            state_nxt  = DRAIN;
            rd_ptr_nxt = SKEW_ROW;
          end
        end
      end
      DRAIN: begin
        out_valid_nxt = 1'b1;
        if (fire) begin
          rd_ptr_nxt = rd_ptr + 1'b1;
          if (rd_ptr == LAST_ROW) begin
            state_nxt     = DONE;
            out_valid_nxt = 1'b0;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SYSBUF_PROTOCOL_CHECK_EN
  logic violation;
  assign violation = (in_valid && state != FILL) || (start && state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_sticky <= 1'b0;
    else if (start && state == IDLE)
      err_sticky <= in_valid;
    else if (violation)
      err_sticky <= 1'b1;
  end

  // Downstream relies on out_data holding while stalled, so rd_ptr may only move on fire.
  rd_ptr_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state == DRAIN && !fire) |=> $stable(rd_ptr));
`endif

endmodule

// File: tb/tb_systolic_buffer_ctrl.sv
// Directed bench for systolic_buffer_ctrl with a behavioural registered-read row buffer.
module tb_systolic_buffer_ctrl;
  localparam int N_SIZE = 32;
  localparam int ROWS   = 512;
  localparam int DEPTH  = 543;
  localparam int AW     = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic buf_we, out_valid, out_last, busy, done;
  logic [AW-1:0] buf_wr_addr, buf_rd_addr;
`ifdef SYSBUF_PROTOCOL_CHECK_EN
  logic err_sticky;
`endif

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  int t0 = 0;

  logic [15:0] mem [0:1023];
  logic [15:0] rd_data;

  systolic_buffer_ctrl #(.N_SIZE(N_SIZE), .ROWS(ROWS), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .out_ready(out_ready),
    .buf_we(buf_we), .buf_wr_addr(buf_wr_addr), .buf_rd_addr(buf_rd_addr),
    .out_valid(out_valid), .out_last(out_last), .busy(busy), .done(done)
`ifdef SYSBUF_PROTOCOL_CHECK_EN
    , .err_sticky(err_sticky)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] row_val(input int a);
    return 16'(a * 7 + 3) ^ 16'h5A3C;
  endfunction

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (buf_we) mem[buf_wr_addr] <= row_val(int'(buf_wr_addr));
    rd_data <= mem[buf_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fill(input bit gap);
    int wr = 0;
    int n = 0;
    while (wr < DEPTH && n < 4000) begin
      in_valid = gap ? (n % 2 == 0) : 1'b1;
      #1;
      chk("fill_busy", 32'(busy), 1);
      if (in_valid) begin
        chk("fill_we", 32'(buf_we), 1);
        chk("fill_addr", 32'(buf_wr_addr), wr);
        wr++;
      end else begin
        chk("fill_gap_we", 32'(buf_we), 0);
      end
      tick();
      n++;
    end
    chk("fill_count", wr, DEPTH);
    in_valid = 1'b1;
    #1;
    chk("drain_entry_we", 32'(buf_we), 0);
    chk("drain_entry_vld", 32'(out_valid), 0);
    chk("drain_entry_rdaddr", 32'(buf_rd_addr), N_SIZE - 1);
    in_valid = 1'b0;
    tick();
  endtask

  task automatic drain(input bit bp, input bit misuse, input bit chk_lat);
    int er = N_SIZE - 1;
    int fired = 0;
    int n = 0;
    logic [3:0] pat = 4'b1001;
    while (fired < ROWS && n < 4000) begin
      out_ready = bp ? pat[n % 4] : 1'b1;
      start = misuse && (n == 5);
      #1;
      chk("drain_vld", 32'(out_valid), 1);
      chk("drain_data", 32'(rd_data), 32'(row_val(er)));
      chk("drain_last", 32'(out_last), (er == DEPTH - 1) ? 1 : 0);
      chk("drain_done", 32'(done), 0);
      if (out_ready) begin
        chk("drain_rdaddr_fire", 32'(buf_rd_addr), er + 1);
        fired++;
        er++;
      end else begin
        chk("drain_rdaddr_hold", 32'(buf_rd_addr), er);
      end
      tick();
      n++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("fired_count", fired, ROWS);
    chk("done_pulse", 32'(done), 1);
    chk("done_vld", 32'(out_valid), 0);
    chk("done_busy", 32'(busy), 1);
    if (chk_lat) chk("latency", cyc_cnt - t0 + 1, 1 + 543 + 1 + 512 + 1);
    tick();
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  task automatic do_start();
    t0 = cyc_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    in_valid = 1'b1;
    #11;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(buf_we), 0);
    chk("rst_vld", 32'(out_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_wr_addr", 32'(buf_wr_addr), 0);
    chk("rst_rd_addr", 32'(buf_rd_addr), N_SIZE - 1);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();

    in_valid = 1'b1;
    #1;
    chk("idle_inval_we", 32'(buf_we), 0);
    tick();
    chk("idle_inval_busy", 32'(busy), 0);
    chk("idle_inval_addr", 32'(buf_wr_addr), 0);
    in_valid = 1'b0;

    do_start();
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      #1;
      chk("pre_rst_addr", 32'(buf_wr_addr), i);
      tick();
    end
    #1;
    chk("pre_rst_we", 32'(buf_we), 1);
    chk("pre_rst_addr100", 32'(buf_wr_addr), 100);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_we", 32'(buf_we), 0);
    chk("midrst_vld", 32'(out_valid), 0);
    chk("midrst_addr", 32'(buf_wr_addr), 0);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();

    do_start();
    fill(1'b0);
    drain(1'b0, 1'b0, 1'b1);

    do_start();
    fill(1'b1);
    drain(1'b0, 1'b0, 1'b0);

    do_start();
    fill(1'b0);
    drain(1'b1, 1'b1, 1'b0);

    in_valid = 1'b1;
    #1;
    chk("end_idle_we", 32'(buf_we), 0);
    tick();
    chk("end_idle_busy", 32'(busy), 0);
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
